// File: rtl/perf_event_monitor.sv
// perf_event_monitor: cycle counter plus NUM_EVENTS event counters with a
// programmable halt limit, sticky overflow flags, and a snapshot that is
// streamed out one word per beat over valid/ready.
//   clk_i, rst_i (async, active-low)
//   start_i, clear_i, event_i[NUM_EVENTS]   : counting control and strobes
//   snap_req_i, snap_ready_i                 : snapshot request / beat accept
//   snap_valid_o, snap_data_o, snap_idx_o,
//   snap_last_o, busy_o                      : readout stream and status
//   done_o, cycle_cnt_o, ovf_o               : live status
module perf_event_monitor #(
  parameter int unsigned NUM_EVENTS  = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned CYCLE_LIMIT = 64,
  parameter int unsigned SATURATE    = 0,
  localparam int unsigned IDX_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  snap_req_i,
  input  logic                  snap_ready_i,
  output logic                  snap_valid_o,
  output logic [CNT_WIDTH-1:0]  snap_data_o,
  output logic [IDX_W-1:0]      snap_idx_o,
  output logic                  snap_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [NUM_EVENTS:0]   ovf_o
);

  localparam int unsigned NCNT = NUM_EVENTS + 1;
  localparam logic [CNT_WIDTH-1:0] LIMIT    = CNT_WIDTH'(CYCLE_LIMIT);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_EVENTS);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  // Slot 0 is the cycle counter, slot k+1 is event channel k.
  logic [CNT_WIDTH-1:0] cnt_q    [NCNT];
  logic [CNT_WIDTH-1:0] cnt_d    [NCNT];
  logic [CNT_WIDTH-1:0] shadow_q [NCNT];
  logic [CNT_WIDTH-1:0] shadow_d [NCNT];
  logic [NUM_EVENTS:0]  ovf_q, ovf_d;
  logic [NUM_EVENTS:0]  inc;
  logic                 done_q, done_d;
  logic                 count_en;
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  always_comb begin
    count_en = start_i & ~done_q & ~clear_i;
    inc      = {event_i & {NUM_EVENTS{count_en}}, count_en};
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    for (int unsigned i = 0; i < NCNT; i++) begin
      if (clear_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          if (SATURATE == 0) begin
            cnt_d[i] = '0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end

    done_d = done_q;
    if (clear_i) begin
      done_d = 1'b0;
    end else if ((CYCLE_LIMIT != 0) && count_en && (cnt_d[0] == LIMIT)) begin
      done_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (snap_req_i) begin
          // Registered values only: this edge's increments/clear are excluded.
          shadow_d = cnt_q;
          idx_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (snap_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q    <= '{default: '0};
      shadow_q <= '{default: '0};
      ovf_q    <= '0;
      done_q   <= 1'b0;
      state_q  <= ST_IDLE;
      idx_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
    end
  end

  // Readout outputs depend on registered state only, never on snap_ready_i.
  always_comb begin
    snap_valid_o = (state_q == ST_SEND);
    snap_data_o  = snap_valid_o ? shadow_q[idx_q] : '0;
    snap_idx_o   = snap_valid_o ? idx_q : '0;
    snap_last_o  = snap_valid_o && (idx_q == LAST_IDX);
    busy_o       = snap_valid_o;
    done_o       = done_q;
    cycle_cnt_o  = cnt_q[0];
    ovf_o        = ovf_q;
  end

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench for perf_event_monitor: a default instance (4 events, 32-bit,
// limit 64) plus two 8-bit, no-limit instances for wrap and saturate.
module tb_perf_event_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, clear, req, rdy;
  logic [3:0] ev;
  logic       ws_start, ws_req, ws_rdy;
  logic [3:0] ws_ev;

  logic        m_valid, m_last, m_busy, m_done;
  logic [31:0] m_data, m_cycle;
  logic [2:0]  m_idx;
  logic [4:0]  m_ovf;

  logic       w_valid, w_last, w_busy, w_done;
  logic [7:0] w_data, w_cycle;
  logic [2:0] w_idx;
  logic [4:0] w_ovf;

  logic       s_valid, s_last, s_busy, s_done;
  logic [7:0] s_data, s_cycle;
  logic [2:0] s_idx;
  logic [4:0] s_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  perf_event_monitor #(
    .NUM_EVENTS(4), .CNT_WIDTH(32), .CYCLE_LIMIT(64), .SATURATE(0)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear),
    .event_i(ev), .snap_req_i(req), .snap_ready_i(rdy),
    .snap_valid_o(m_valid), .snap_data_o(m_data), .snap_idx_o(m_idx),
    .snap_last_o(m_last), .busy_o(m_busy), .done_o(m_done),
    .cycle_cnt_o(m_cycle), .ovf_o(m_ovf)
  );

  perf_event_monitor #(
    .NUM_EVENTS(4), .CNT_WIDTH(8), .CYCLE_LIMIT(0), .SATURATE(0)
  ) dut_w (
    .clk_i(clk), .rst_i(rst_n), .start_i(ws_start), .clear_i(1'b0),
    .event_i(ws_ev), .snap_req_i(ws_req), .snap_ready_i(ws_rdy),
    .snap_valid_o(w_valid), .snap_data_o(w_data), .snap_idx_o(w_idx),
    .snap_last_o(w_last), .busy_o(w_busy), .done_o(w_done),
    .cycle_cnt_o(w_cycle), .ovf_o(w_ovf)
  );

  perf_event_monitor #(
    .NUM_EVENTS(4), .CNT_WIDTH(8), .CYCLE_LIMIT(0), .SATURATE(1)
  ) dut_s (
    .clk_i(clk), .rst_i(rst_n), .start_i(ws_start), .clear_i(1'b0),
    .event_i(ws_ev), .snap_req_i(ws_req), .snap_ready_i(ws_rdy),
    .snap_valid_o(s_valid), .snap_data_o(s_data), .snap_idx_o(s_idx),
    .snap_last_o(s_last), .busy_o(s_busy), .done_o(s_done),
    .cycle_cnt_o(s_cycle), .ovf_o(s_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; returns on the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] idx,
                          input logic [31:0] data, input logic last);
    chk({tag, ".valid"}, m_valid, 1'b1);
    chk({tag, ".idx"},   m_idx,   idx);
    chk({tag, ".data"},  m_data,  data);
    chk({tag, ".last"},  m_last,  last);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; req = 1'b0; rdy = 1'b0; ev = '0;
    ws_start = 1'b0; ws_req = 1'b0; ws_rdy = 1'b0; ws_ev = '0;

    // Reset state
    #12;
    chk("rst.valid", m_valid, 1'b0);
    chk("rst.data",  m_data,  32'd0);
    chk("rst.idx",   m_idx,   3'd0);
    chk("rst.last",  m_last,  1'b0);
    chk("rst.busy",  m_busy,  1'b0);
    chk("rst.done",  m_done,  1'b0);
    chk("rst.cycle", m_cycle, 32'd0);
    chk("rst.ovf",   m_ovf,   5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic counting: ch0=10, ch1=3, ch3=7, halt at 64
    start = 1'b1; ev = 4'b0011;
    step(3);
    ev = 4'b0001;
    step(7);
    chk("cnt.cycle10", m_cycle, 32'd10);
    ev = 4'b0000;
    step(10);
    ev = 4'b1000;
    step(7);
    ev = 4'b0000;
    step(36);
    chk("cnt.cycle63", m_cycle, 32'd63);
    chk("cnt.done63",  m_done,  1'b0);
    step(1);
    chk("cnt.cycle64", m_cycle, 32'd64);
    chk("cnt.done64",  m_done,  1'b1);
    ev = 4'b1111;
    step(3);
    chk("cnt.hold",    m_cycle, 32'd64);
    start = 1'b0; ev = 4'b0000;
    step(2);
    chk("cnt.done_sticky", m_done, 1'b1);
    chk("cnt.ovf",     m_ovf,   5'd0);

    // Backpressure readout of {64,10,3,0,7}
    req = 1'b1; rdy = 1'b0;
    step(1);
    chk("bp.busy0", m_busy, 1'b1);
    chk_beat("bp.b0", 3'd0, 32'd64, 1'b0);
    req = 1'b0; rdy = 1'b1;
    step(1);
    chk_beat("bp.b1", 3'd1, 32'd10, 1'b0);
    rdy = 1'b0; req = 1'b1;
    step(1);
    chk_beat("bp.b1h1", 3'd1, 32'd10, 1'b0);
    step(1);
    chk_beat("bp.b1h2", 3'd1, 32'd10, 1'b0);
    req = 1'b0; rdy = 1'b1;
    step(1);
    chk_beat("bp.b2", 3'd2, 32'd3, 1'b0);
    step(1);
    chk_beat("bp.b3", 3'd3, 32'd0, 1'b0);
    step(1);
    chk_beat("bp.b4", 3'd4, 32'd7, 1'b1);
    rdy = 1'b0;
    step(1);
    chk_beat("bp.b4h", 3'd4, 32'd7, 1'b1);
    chk("bp.busy_h", m_busy, 1'b1);
    rdy = 1'b1;
    step(1);
    chk("bp.busy_end",  m_busy,  1'b0);
    chk("bp.valid_end", m_valid, 1'b0);
    chk("bp.last_end",  m_last,  1'b0);
    step(1);
    chk("bp.noqueue", m_busy, 1'b0);

    // Clear after done
    start = 1'b1; clear = 1'b1;
    step(1);
    chk("clr.done",  m_done,  1'b0);
    chk("clr.cycle", m_cycle, 32'd0);
    chk("clr.ovf",   m_ovf,   5'd0);
    clear = 1'b0;
    step(1);
    chk("clr.resume", m_cycle, 32'd1);

    // Snapshot coherency: req + event + clear on one edge
    ev = 4'b0001;
    step(2);
    chk("coh.pre_cycle", m_cycle, 32'd3);
    req = 1'b1; clear = 1'b1; rdy = 1'b0;
    step(1);
    chk("coh.live0", m_cycle, 32'd0);
    chk_beat("coh.b0", 3'd0, 32'd3, 1'b0);
    req = 1'b0; clear = 1'b0; ev = 4'b0000; rdy = 1'b1;
    step(1);
    chk_beat("coh.b1", 3'd1, 32'd2, 1'b0);
    chk("coh.live1", m_cycle, 32'd1);
    step(1);
    chk_beat("coh.b2", 3'd2, 32'd0, 1'b0);
    step(2);
    chk_beat("coh.b4", 3'd4, 32'd0, 1'b1);
    step(1);
    chk("coh.busy_end", m_busy, 1'b0);

    // Asynchronous reset mid-readout
    req = 1'b1; rdy = 1'b0;
    step(1);
    chk("ar.busy_pre", m_busy, 1'b1);
    req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.busy",  m_busy,  1'b0);
    chk("ar.valid", m_valid, 1'b0);
    chk("ar.data",  m_data,  32'd0);
    chk("ar.idx",   m_idx,   3'd0);
    chk("ar.cycle", m_cycle, 32'd0);
    chk("ar.done",  m_done,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("ar.restart", m_cycle, 32'd1);
    chk("ar.idle_busy", m_busy, 1'b0);
    start = 1'b0;

    // Wrap vs saturate: 257 strobes on channel 0, 8-bit counters
    chk("ws.w_init", w_cycle, 8'd0);
    ws_start = 1'b1; ws_ev = 4'b0001;
    step(257);
    chk("ws.w_cycle", w_cycle, 8'd1);
    chk("ws.w_ovf",   w_ovf,   5'b00011);
    chk("ws.s_cycle", s_cycle, 8'd255);
    chk("ws.s_ovf",   s_ovf,   5'b00011);
    ws_start = 1'b0; ws_ev = 4'b0000; ws_req = 1'b1; ws_rdy = 1'b1;
    step(1);
    chk("ws.w_b0", w_data, 8'd1);
    chk("ws.s_b0", s_data, 8'd255);
    ws_req = 1'b0;
    step(1);
    chk("ws.w_idx1", w_idx,  3'd1);
    chk("ws.w_ch0",  w_data, 8'd1);
    chk("ws.s_ch0",  s_data, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
